// File: rtl/fft_pkg.sv
// Shared fixed-point constants, payload type and Q8.8 helpers for the FFT datapath.
package fft_pkg;

  localparam int unsigned Q_W    = 16;
  localparam int unsigned Q_FRAC = 8;
  localparam int unsigned TW_AW  = 5;
  localparam int unsigned MUL_W  = 2 * Q_W;
  localparam int unsigned PROD_W = MUL_W + 1;
  localparam int unsigned BIAS_W = PROD_W + 1;
  localparam int unsigned RND_W  = PROD_W - Q_FRAC;
  localparam int unsigned SUM_W  = Q_W + 1;

  typedef struct packed {
    logic signed [Q_W-1:0] re;
    logic signed [Q_W-1:0] im;
  } cplx_t;

  // Clamp a wide signed value into the 16-bit signed range.
  function automatic logic signed [Q_W-1:0] sat16(input logic signed [RND_W-1:0] x);
    if (x > RND_W'(32'sd32767)) return Q_W'(32'sd32767);
    if (x < RND_W'(-32'sd32768)) return Q_W'(-32'sd32768);
    return Q_W'(x);
  endfunction

  // Round-half-up a full-precision Q16.16 product back to Q8.8 scale.
  function automatic logic signed [RND_W-1:0] round_q88(input logic signed [PROD_W-1:0] x);
    logic signed [BIAS_W-1:0] biased;
    biased = BIAS_W'(x) + BIAS_W'(32'sd1 <<< (Q_FRAC - 1));
    return RND_W'(biased >>> Q_FRAC);
  endfunction

endpackage

// File: rtl/fft_butterfly_stage_cmplx_mul_q88.sv
// Combinational Q8.8 complex multiply with rounding and saturation.
module cmplx_mul_q88
  import fft_pkg::*;
(
  input  cplx_t b,
  input  cplx_t w,
  output cplx_t p
);

  logic signed [MUL_W-1:0]  rr, ii, ri, ir;
  logic signed [PROD_W-1:0] acc_re, acc_im;

  // Four full-precision partial products, combined at 33 bits then rounded and clamped.
  always_comb begin
    rr     = MUL_W'(b.re) * MUL_W'(w.re);
    ii     = MUL_W'(b.im) * MUL_W'(w.im);
    ri     = MUL_W'(b.re) * MUL_W'(w.im);
    ir     = MUL_W'(b.im) * MUL_W'(w.re);
    acc_re = PROD_W'(rr) - PROD_W'(ii);
    acc_im = PROD_W'(ri) + PROD_W'(ir);
    p.re   = sat16(round_q88(acc_re));
    p.im   = sat16(round_q88(acc_im));
  end

endmodule

// File: rtl/fft_butterfly_stage.sv
// Radix-2 DIT butterfly for FFT stage 5: X = A + W*B, Y = A - W*B, 3-stage pipeline.
module fft_butterfly_stage
  import fft_pkg::*;
#(
  parameter int unsigned NUM_TW = 28,
  parameter int unsigned SCALE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic signed [Q_W-1:0] in_a_re,
  input  logic signed [Q_W-1:0] in_a_im,
  input  logic signed [Q_W-1:0] in_b_re,
  input  logic signed [Q_W-1:0] in_b_im,
  output logic [TW_AW-1:0]      tw_addr,
  input  logic signed [Q_W-1:0] tw_re,
  input  logic signed [Q_W-1:0] tw_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [Q_W-1:0] out_x_re,
  output logic signed [Q_W-1:0] out_x_im,
  output logic signed [Q_W-1:0] out_y_re,
  output logic signed [Q_W-1:0] out_y_im,
  output logic                  out_last
);

  localparam logic [TW_AW-1:0] LAST_ADDR = TW_AW'(NUM_TW - 1);

  logic              stall, accept;
  logic [TW_AW-1:0]  cnt, beat_addr;
  logic              s1_valid, s1_last;
  logic [TW_AW-1:0]  s1_addr;
  cplx_t             s1_a, s1_b;
  logic              s2_valid, s2_last;
  cplx_t             s2_a, s2_p;
  cplx_t             tw, prod;
  logic signed [SUM_W-1:0] sum_xr, sum_xi, sum_yr, sum_yi;

  // Either halve (truncating) or saturate a 17-bit butterfly sum to 16 bits.
  function automatic logic signed [Q_W-1:0] fit(input logic signed [SUM_W-1:0] s);
    if (SCALE != 0) return Q_W'(s >>> 1);
    return sat16(RND_W'(s));
  endfunction

  // Handshake, beat address and ROM address; the ROM address is held during a stall.
  always_comb begin
    stall     = out_valid && !out_ready;
    in_ready  = !stall;
    accept    = in_valid && !stall;
    beat_addr = in_first ? '0 : cnt;
    tw_addr   = stall ? s1_addr : ((in_valid && in_first) ? '0 : cnt);
    tw        = '{re: tw_re, im: tw_im};
  end

  cmplx_mul_q88 u_mul (
    .b (s1_b),
    .w (tw),
    .p (prod)
  );

  // Butterfly add/subtract on the S2 contents at 17 bits.
  always_comb begin
    sum_xr = SUM_W'(s2_a.re) + SUM_W'(s2_p.re);
    sum_xi = SUM_W'(s2_a.im) + SUM_W'(s2_p.im);
    sum_yr = SUM_W'(s2_a.re) - SUM_W'(s2_p.re);
    sum_yi = SUM_W'(s2_a.im) - SUM_W'(s2_p.im);
  end

  // Pipeline registers and address counter; everything freezes while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_addr   <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_a      <= '0;
      s2_p      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_x_re  <= '0;
      out_x_im  <= '0;
      out_y_re  <= '0;
      out_y_im  <= '0;
    end else if (!stall) begin
      if (accept) cnt <= (beat_addr == LAST_ADDR) ? '0 : beat_addr + TW_AW'(1);
      s1_valid  <= in_valid;
      s1_last   <= in_valid && (beat_addr == LAST_ADDR);
      s1_addr   <= beat_addr;
      s1_a      <= '{re: in_a_re, im: in_a_im};
      s1_b      <= '{re: in_b_re, im: in_b_im};
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      s2_a      <= s1_a;
      s2_p      <= prod;
      out_valid <= s2_valid;
      out_last  <= s2_last;
      out_x_re  <= fit(sum_xr);
      out_x_im  <= fit(sum_xi);
      out_y_re  <= fit(sum_yr);
      out_y_im  <= fit(sum_yi);
    end
  end

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Directed bench for fft_butterfly_stage with a registered twiddle ROM model.
module tb_fft_butterfly_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_first = 1'b0;
  logic [15:0] in_a_re = '0, in_a_im = '0, in_b_re = '0, in_b_im = '0;
  logic [4:0]  tw_addr;
  logic [15:0] tw_re, tw_im;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_x_re, out_x_im, out_y_re, out_y_im;
  logic        out_last;

  logic [15:0] rom_re [32];
  logic [15:0] rom_im [32];

  int   checks = 0;
  int   errors = 0;
  int   nb, nout;
  logic took;

  fft_butterfly_stage #(.NUM_TW(28), .SCALE(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_a_re   (in_a_re),
    .in_a_im   (in_a_im),
    .in_b_re   (in_b_re),
    .in_b_im   (in_b_im),
    .tw_addr   (tw_addr),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x_re  (out_x_re),
    .out_x_im  (out_x_im),
    .out_y_re  (out_y_re),
    .out_y_im  (out_y_im),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Twiddle ROMs: address captured on the rising edge, data one cycle later.
  always @(posedge clk) begin
    tw_re <= rom_re[tw_addr];
    tw_im <= rom_im[tw_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic first, input logic [15:0] are, aim, bre, bim);
    in_valid = 1'b1;
    in_first = first;
    in_a_re  = are;
    in_a_im  = aim;
    in_b_re  = bre;
    in_b_im  = bim;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: address, 3-cycle latency, then results.
  task automatic one_beat(input logic first, input logic [15:0] are, aim, bre, bim,
                          input logic [4:0] eaddr,
                          input logic [15:0] exr, exi, eyr, eyi, input logic elast);
    out_ready = 1'b1;
    set_in(first, are, aim, bre, bim);
    @(negedge clk);
    check("beat_addr", tw_addr, eaddr);
    check("beat_ready", in_ready, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    in_first = 1'b0;
    @(negedge clk);
    check("lat_c2_valid", out_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    check("lat_c3_valid", out_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    check("lat_out_valid", out_valid, 1'b1);
    check("x_re", out_x_re, exr);
    check("x_im", out_x_im, exi);
    check("y_re", out_y_re, eyr);
    check("y_im", out_y_im, eyi);
    check("last", out_last, elast);
    next_cycle();
  endtask

  // Ramp ROM: W[a] = (a+1).0, so B=(0x0001,0) yields P_re = a+1 (raw).
  task automatic fill_rom_ramp();
    for (int a = 0; a < 32; a++) begin
      rom_re[a] = 16'((a + 1) << 8);
      rom_im[a] = 16'h0000;
    end
  endtask

  function automatic logic [15:0] exp_x(input int k, input int addr);
    return 16'((k << 8) + addr + 1);
  endfunction

  function automatic logic [15:0] exp_y(input int k, input int addr);
    return 16'((k << 8) - (addr + 1));
  endfunction

  initial begin
    for (int a = 0; a < 32; a++) begin
      rom_re[a] = '0;
      rom_im[a] = '0;
    end
    rom_re[0] = 16'h0100; rom_im[0] = 16'h0000;
    rom_re[1] = 16'h0000; rom_im[1] = 16'hFF00;
    rom_re[2] = 16'h0100; rom_im[2] = 16'h0000;
    rom_re[3] = 16'h0080; rom_im[3] = 16'h0000;

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_tw_addr", tw_addr, 5'd0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_x_re", out_x_re, 16'h0000);
    check("rst_out_y_im", out_y_im, 16'h0000);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    next_cycle();

    // Directed butterflies at addresses 0..3
    one_beat(1'b1, 16'h0200, 16'h0000, 16'h0100, 16'h0080, 5'd0,
             16'h0300, 16'h0080, 16'h0100, 16'hFF80, 1'b0);
    one_beat(1'b0, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 5'd1,
             16'h0000, 16'hFF00, 16'h0000, 16'h0100, 1'b0);
    one_beat(1'b0, 16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 5'd2,
             16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    one_beat(1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 5'd3,
             16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1'b0);

    // 30 back-to-back beats across the address wrap
    fill_rom_ramp();
    out_ready = 1'b1;
    for (int i = 0; i < 33; i++) begin
      if (i < 30) set_in(i == 0, 16'(i << 8), 16'h0000, 16'h0001, 16'h0000);
      else begin
        in_valid = 1'b0;
        in_first = 1'b0;
      end
      @(negedge clk);
      if (i < 30) begin
        check("b2b_addr", tw_addr, 32'(i % 28));
        check("b2b_ready", in_ready, 1'b1);
      end
      if (i >= 3) begin
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_x_re", out_x_re, exp_x(i - 3, (i - 3) % 28));
        check("b2b_last", out_last, (i - 3) == 27);
      end
      next_cycle();
    end
    @(negedge clk);
    check("b2b_drained", out_valid, 1'b0);
    next_cycle();

    // Backpressure: out_ready low for 5 cycles mid-frame
    nb   = 0;
    nout = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (nb < 10) set_in(nb == 0, 16'(nb << 8), 16'h0000, 16'h0001, 16'h0000);
      else begin
        in_valid = 1'b0;
        in_first = 1'b0;
      end
      out_ready = !(cyc >= 6 && cyc < 11);
      @(negedge clk);
      took = in_valid && in_ready;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_tw_addr", tw_addr, 32'(nb - 1));
        check("stall_hold_x", out_x_re, exp_x(nout, nout));
        check("stall_hold_y", out_y_re, exp_y(nout, nout));
      end else begin
        check("run_in_ready", in_ready, 1'b1);
        if (took) check("run_tw_addr", tw_addr, 32'(nb));
        if (out_valid) begin
          check("run_x_re", out_x_re, exp_x(nout, nout));
          check("run_y_re", out_y_re, exp_y(nout, nout));
          nout++;
        end
      end
      next_cycle();
      if (took) nb++;
    end
    check("stall_beats_in", nb, 10);
    check("stall_beats_out", nout, 10);

    // Reset with two beats in flight
    out_ready = 1'b1;
    set_in(1'b1, 16'h0500, 16'h0000, 16'h0001, 16'h0000);
    next_cycle();
    set_in(1'b0, 16'h0600, 16'h0000, 16'h0001, 16'h0000);
    next_cycle();
    in_valid = 1'b0;
    in_first = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_tw_addr", tw_addr, 5'd0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_x_re", out_x_re, 16'h0000);
    next_cycle();
    @(negedge clk);
    check("mid_rst_flush1", out_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    check("mid_rst_flush2", out_valid, 1'b0);
    next_cycle();
    one_beat(1'b0, 16'h0300, 16'h0000, 16'h0001, 16'h0000, 5'd0,
             16'h0301, 16'h0000, 16'h02FF, 16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
